pipe_ctrl: RTL and testbench

Central pipeline sequencer for the 5-stage RISC-V core. It combines the load-use stall from the hazard unit, EX-stage branch/jump redirects, data-memory busy and halt/resume requests. From these it drives the per-stage register write-enables and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It also provides halt draining, a data-memory wait watchdog and optional performance counters.

---
 rtl/pipe_ctrl_if.sv | 34 +++
 rtl/pipe_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus between the sequencer (master) and the pipeline datapath (slave).
// The two counter fields are only meaningful when pipe_ctrl is built with PIPE_CTRL_PERF_EN.
interface pipe_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             hazard_stall;
    logic             branch_taken;
    logic             dmem_busy;
    logic             halt_req;
    logic             resume;
    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_we;
    logic             idex_flush;
    logic             exmem_we;
    logic             memwb_we;
    logic             halted;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        input  hazard_stall, branch_taken, dmem_busy, halt_req, resume,
        output pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_we,
        output halted, mem_timeout, stall_cnt, flush_cnt
    );

    modport slave (
        output hazard_stall, branch_taken, dmem_busy, halt_req, resume,
        input  pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_we,
        input  halted, mem_timeout, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stage write-enables/flushes, redirect flushing, halt draining, dmem watchdog.
// Optional performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int DRAIN_CYCLES = 4,
    parameter int MAX_MEM_WAIT = 15,
    parameter int CNT_W        = 32
) (
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl_if.master  bus
);
    localparam int          DW     = $clog2(DRAIN_CYCLES + 1);
    localparam logic [2:0]  RLOAD  = 3'(FLUSH_CYCLES - 1);
    localparam logic [DW-1:0] DMAX = DW'(DRAIN_CYCLES);
    localparam logic [7:0]  WMAX   = 8'(MAX_MEM_WAIT);

    typedef enum logic [1:0] {RUN, REDIRECT, HALT} state_t;

    state_t        state_q, state_d;
    logic [2:0]    rcnt_q, rcnt_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [7:0]    wcnt_q, wcnt_d;
    logic          mem_timeout_q, mem_timeout_d;

    logic pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_we;
    logic halted, mem_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            rcnt_q        <= '0;
            dcnt_q        <= '0;
            wcnt_q        <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rcnt_q        <= rcnt_d;
            dcnt_q        <= dcnt_d;
            wcnt_q        <= wcnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        rcnt_d        = rcnt_q;
        dcnt_d        = dcnt_q;
        wcnt_d        = '0;
        mem_timeout_d = mem_timeout_q;
        pc_we         = 1'b0;
        ifid_we       = 1'b0;
        ifid_flush    = 1'b0;
        idex_we       = 1'b0;
        idex_flush    = 1'b0;
        exmem_we      = 1'b0;
        memwb_we      = 1'b0;
        halted        = (state_q == HALT) && (dcnt_q == DMAX);
        mem_timeout   = mem_timeout_q;

        if (rst) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            halted      = 1'b0;
            mem_timeout = 1'b0;
        end else if (bus.dmem_busy) begin
            // Freeze everything; a stuck access forces a drain into HALT.
            wcnt_d = (wcnt_q == WMAX) ? WMAX : wcnt_q + 8'd1;
            if (wcnt_d == WMAX) begin
                mem_timeout_d = 1'b1;
                state_d       = HALT;
                dcnt_d        = '0;
            end
        end else begin
            unique case (state_q)
                RUN: begin
                    if (bus.branch_taken) begin
                        pc_we      = 1'b1;
                        ifid_we    = 1'b1;
                        ifid_flush = 1'b1;
                        idex_we    = 1'b1;
                        idex_flush = 1'b1;
                        exmem_we   = 1'b1;
                        memwb_we   = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_d = REDIRECT;
                            rcnt_d  = RLOAD;
                        end
                    end else if (bus.hazard_stall) begin
                        idex_we    = 1'b1;
                        idex_flush = 1'b1;
                        exmem_we   = 1'b1;
                        memwb_we   = 1'b1;
                    end else if (bus.halt_req) begin
                        ifid_we    = 1'b1;
                        ifid_flush = 1'b1;
                        idex_we    = 1'b1;
                        exmem_we   = 1'b1;
                        memwb_we   = 1'b1;
                        state_d    = HALT;
                        dcnt_d     = '0;
                    end else begin
                        pc_we    = 1'b1;
                        ifid_we  = 1'b1;
                        idex_we  = 1'b1;
                        exmem_we = 1'b1;
                        memwb_we = 1'b1;
                    end
                end
                REDIRECT: begin
                    pc_we      = 1'b1;
                    ifid_we    = 1'b1;
                    ifid_flush = 1'b1;
                    idex_we    = 1'b1;
                    exmem_we   = 1'b1;
                    memwb_we   = 1'b1;
                    if (bus.branch_taken) begin
                        idex_flush = 1'b1;
                        rcnt_d     = RLOAD;
                    end else if (rcnt_q == 3'd1) begin
                        state_d = RUN;
                        rcnt_d  = '0;
                    end else begin
                        rcnt_d = rcnt_q - 3'd1;
                    end
                end
                HALT: begin
                    ifid_flush = 1'b1;
                    idex_we    = 1'b1;
                    exmem_we   = 1'b1;
                    memwb_we   = 1'b1;
                    dcnt_d     = (dcnt_q == DMAX) ? DMAX : dcnt_q + DW'(1);
                    if (bus.resume && halted) begin
                        state_d = RUN;
                        dcnt_d  = '0;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    assign bus.pc_we       = pc_we;
    assign bus.ifid_we     = ifid_we;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_we     = idex_we;
    assign bus.idex_flush  = idex_flush;
    assign bus.exmem_we    = exmem_we;
    assign bus.memwb_we    = memwb_we;
    assign bus.halted      = halted;
    assign bus.mem_timeout = mem_timeout;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             stall_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Counters saturate rather than wrap so long runs never read as small values.
    always_comb begin
        stall_hit   = !rst && !bus.dmem_busy && (state_q == RUN) &&
                      !bus.branch_taken && bus.hazard_stall;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_hit && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (ifid_flush && !rst && !(&flush_cnt_q))
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
`else
    assign bus.stall_cnt = {CNT_W{1'b0}};
    assign bus.flush_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl; each task drives one scenario and checks hand-computed controls.
// Counter checks follow PIPE_CTRL_PERF_EN (expected zero when the feature is not built).
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst;

    pipe_ctrl_if #(.CNT_W(32)) bus ();

    pipe_ctrl #(
        .FLUSH_CYCLES(2),
        .DRAIN_CYCLES(4),
        .MAX_MEM_WAIT(15),
        .CNT_W(32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Control vector bit order: pc_we ifid_we ifid_flush idex_we idex_flush exmem_we memwb_we
    logic [6:0] ctrl;
    assign ctrl = {bus.pc_we, bus.ifid_we, bus.ifid_flush, bus.idex_we,
                   bus.idex_flush, bus.exmem_we, bus.memwb_we};

    localparam logic [6:0] C_RESET = 7'b0010100;
    localparam logic [6:0] C_RUN   = 7'b1101011;
    localparam logic [6:0] C_STALL = 7'b0000111;
    localparam logic [6:0] M_STALL = 7'b1110111;
    localparam logic [6:0] C_BR    = 7'b1111111;
    localparam logic [6:0] C_REDIR = 7'b1111011;
    localparam logic [6:0] C_HREQ  = 7'b0111011;
    localparam logic [6:0] C_HALT  = 7'b0011011;
    localparam logic [6:0] M_HALT  = 7'b1011111;
    localparam logic [6:0] C_BUSY  = 7'b0000000;

    // Apply one cycle of inputs away from the rising edge, then settle before checking.
    task automatic drive(input logic hz, input logic br, input logic bz,
                         input logic hr, input logic rs);
        @(negedge clk);
        bus.hazard_stall = hz;
        bus.branch_taken = br;
        bus.dmem_busy    = bz;
        bus.halt_req     = hr;
        bus.resume       = rs;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0);
            vec_cnt++;
            if ({ctrl, bus.halted, bus.mem_timeout} !== {C_RESET, 2'b00}) begin
                err_cnt++;
                $display("[TB] FAIL reset_ctrl[%0d]: got %b expected %b", i,
                         {ctrl, bus.halted, bus.mem_timeout}, {C_RESET, 2'b00});
            end
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vec_cnt++;
        if ({ctrl, bus.halted, bus.mem_timeout} !== {C_RUN, 2'b00}) begin
            err_cnt++;
            $display("[TB] FAIL reset_release: got %b expected %b",
                     {ctrl, bus.halted, bus.mem_timeout}, {C_RUN, 2'b00});
        end
        vec_cnt++;
        if ({bus.stall_cnt, bus.flush_cnt} !== 64'd0) begin
            err_cnt++;
            $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0",
                     bus.stall_cnt, bus.flush_cnt);
        end
    endtask

    task automatic test_stall;
        drive(1, 0, 0, 0, 0);
        vec_cnt++;
        if ((ctrl & M_STALL) !== C_STALL) begin
            err_cnt++;
            $display("[TB] FAIL stall_ctrl: got %b expected %b", ctrl & M_STALL, C_STALL);
        end
        drive(0, 0, 0, 0, 0);
        vec_cnt++;
        if (ctrl !== C_RUN) begin
            err_cnt++;
            $display("[TB] FAIL stall_after: got %b expected %b", ctrl, C_RUN);
        end
        vec_cnt++;
`ifdef PIPE_CTRL_PERF_EN
        if (bus.stall_cnt !== 32'd1) begin
            err_cnt++;
            $display("[TB] FAIL stall_cnt: got %0d expected 1", bus.stall_cnt);
        end
`else
        if (bus.stall_cnt !== 32'd0) begin
            err_cnt++;
            $display("[TB] FAIL stall_cnt: got %0d expected 0", bus.stall_cnt);
        end
`endif
    endtask

    task automatic test_branch;
        logic [6:0] exp_seq [3];
        exp_seq[0] = C_BR;
        exp_seq[1] = C_REDIR;
        exp_seq[2] = C_RUN;
        for (int i = 0; i < 3; i++) begin
            // hazard held through the redirect cycle: must lose to branch, then be ignored
            drive((i < 2) ? 1'b1 : 1'b0, (i == 0) ? 1'b1 : 1'b0, 0, 0, 0);
            vec_cnt++;
            if (ctrl !== exp_seq[i]) begin
                err_cnt++;
                $display("[TB] FAIL branch_ctrl[%0d]: got %b expected %b", i, ctrl, exp_seq[i]);
            end
        end
        vec_cnt++;
`ifdef PIPE_CTRL_PERF_EN
        if ({bus.stall_cnt, bus.flush_cnt} !== {32'd1, 32'd2}) begin
            err_cnt++;
            $display("[TB] FAIL branch_counters: got %0d/%0d expected 1/2",
                     bus.stall_cnt, bus.flush_cnt);
        end
`else
        if ({bus.stall_cnt, bus.flush_cnt} !== 64'd0) begin
            err_cnt++;
            $display("[TB] FAIL branch_counters: got %0d/%0d expected 0/0",
                     bus.stall_cnt, bus.flush_cnt);
        end
`endif
    endtask

    task automatic test_back_to_back;
        logic [6:0] exp_seq [4];
        exp_seq[0] = C_BR;
        exp_seq[1] = C_BR;
        exp_seq[2] = C_REDIR;
        exp_seq[3] = C_RUN;
        for (int i = 0; i < 4; i++) begin
            drive(0, (i < 2) ? 1'b1 : 1'b0, 0, 0, 0);
            vec_cnt++;
            if (ctrl !== exp_seq[i]) begin
                err_cnt++;
                $display("[TB] FAIL b2b_ctrl[%0d]: got %b expected %b", i, ctrl, exp_seq[i]);
            end
        end
    endtask

    task automatic test_busy_redirect;
        logic [6:0] exp_seq [6];
        exp_seq[0] = C_BR;
        exp_seq[1] = C_BUSY;
        exp_seq[2] = C_BUSY;
        exp_seq[3] = C_BUSY;
        exp_seq[4] = C_REDIR;
        exp_seq[5] = C_RUN;
        for (int i = 0; i < 6; i++) begin
            drive(0, (i == 0) ? 1'b1 : 1'b0, (i >= 1 && i <= 3) ? 1'b1 : 1'b0, 0, 0);
            vec_cnt++;
            if (ctrl !== exp_seq[i]) begin
                err_cnt++;
                $display("[TB] FAIL busy_redir[%0d]: got %b expected %b", i, ctrl, exp_seq[i]);
            end
        end
    endtask

    task automatic test_timeout;
        for (int i = 0; i < 15; i++) begin
            drive(0, 0, 1, 0, 0);
            vec_cnt++;
            if ({ctrl, bus.mem_timeout} !== {C_BUSY, 1'b0}) begin
                err_cnt++;
                $display("[TB] FAIL timeout_busy[%0d]: got %b expected %b", i,
                         {ctrl, bus.mem_timeout}, {C_BUSY, 1'b0});
            end
        end
        // dcnt runs 0..4 after busy drops; resume accompanies the halted cycle
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, (i == 4) ? 1'b1 : 1'b0);
            vec_cnt++;
            if ({ctrl & M_HALT, bus.halted, bus.mem_timeout} !==
                {C_HALT, (i == 4) ? 1'b1 : 1'b0, 1'b1}) begin
                err_cnt++;
                $display("[TB] FAIL timeout_drain[%0d]: got %b expected %b", i,
                         {ctrl & M_HALT, bus.halted, bus.mem_timeout},
                         {C_HALT, (i == 4) ? 1'b1 : 1'b0, 1'b1});
            end
        end
        drive(0, 0, 0, 0, 0);
        vec_cnt++;
        if ({ctrl, bus.halted, bus.mem_timeout} !== {C_RUN, 2'b01}) begin
            err_cnt++;
            $display("[TB] FAIL timeout_resume: got %b expected %b",
                     {ctrl, bus.halted, bus.mem_timeout}, {C_RUN, 2'b01});
        end
        vec_cnt++;
`ifdef PIPE_CTRL_PERF_EN
        if ({bus.stall_cnt, bus.flush_cnt} !== {32'd1, 32'd12}) begin
            err_cnt++;
            $display("[TB] FAIL timeout_counters: got %0d/%0d expected 1/12",
                     bus.stall_cnt, bus.flush_cnt);
        end
`else
        if ({bus.stall_cnt, bus.flush_cnt} !== 64'd0) begin
            err_cnt++;
            $display("[TB] FAIL timeout_counters: got %0d/%0d expected 0/0",
                     bus.stall_cnt, bus.flush_cnt);
        end
`endif
    endtask

    task automatic test_halt_resume;
        logic [6:0] exp_seq [7];
        logic [6:0] msk_seq [7];
        logic       hlt_seq [7];
        logic       hr_seq  [7];
        logic       rs_seq  [7];
        // sticky timeout from the previous scenario must clear only through reset
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        vec_cnt++;
        if (bus.mem_timeout !== 1'b0) begin
            err_cnt++;
            $display("[TB] FAIL halt_rst_timeout: got %b expected 0", bus.mem_timeout);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vec_cnt++;
        if ({ctrl, bus.mem_timeout} !== {C_RUN, 1'b0}) begin
            err_cnt++;
            $display("[TB] FAIL halt_rst_release: got %b expected %b",
                     {ctrl, bus.mem_timeout}, {C_RUN, 1'b0});
        end
        exp_seq = '{C_HREQ, C_HALT, C_HALT, C_HALT, C_HALT, C_HALT, C_RUN};
        msk_seq = '{7'h7f, M_HALT, M_HALT, M_HALT, M_HALT, M_HALT, 7'h7f};
        hlt_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        hr_seq  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        rs_seq  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, 0, hr_seq[i], rs_seq[i]);
            vec_cnt++;
            if ({ctrl & msk_seq[i], bus.halted} !== {exp_seq[i], hlt_seq[i]}) begin
                err_cnt++;
                $display("[TB] FAIL halt_seq[%0d]: got %b expected %b", i,
                         {ctrl & msk_seq[i], bus.halted}, {exp_seq[i], hlt_seq[i]});
            end
        end
        vec_cnt++;
`ifdef PIPE_CTRL_PERF_EN
        if ({bus.stall_cnt, bus.flush_cnt} !== {32'd0, 32'd6}) begin
            err_cnt++;
            $display("[TB] FAIL halt_counters: got %0d/%0d expected 0/6",
                     bus.stall_cnt, bus.flush_cnt);
        end
`else
        if ({bus.stall_cnt, bus.flush_cnt} !== 64'd0) begin
            err_cnt++;
            $display("[TB] FAIL halt_counters: got %0d/%0d expected 0/0",
                     bus.stall_cnt, bus.flush_cnt);
        end
`endif
    endtask

    initial begin
        rst              = 1'b1;
        bus.hazard_stall = 1'b0;
        bus.branch_taken = 1'b0;
        bus.dmem_busy    = 1'b0;
        bus.halt_req     = 1'b0;
        bus.resume       = 1'b0;
        test_reset();
        test_stall();
        test_branch();
        test_back_to_back();
        test_busy_redirect();
        test_timeout();
        test_halt_resume();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
